note_player: RTL and testbench

Reads the music ROM and turns its note words into a square-wave speaker output. It drives the ROM address as {song select, 7-bit note index} and samples the ROM data word. It holds each note for its encoded number of beats, then advances to the next word. It sits between the song ROM and the speaker pin, with `en`/`sel` coming from the board switches.

---
 rtl/music_pkg.sv | 42 ++++
 rtl/tone_gen.sv | 43 ++++
 rtl/note_player.sv | 102 ++++++++++
 tb/tb_note_player.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/music_pkg.sv
// Shared types and constants for the song player: FSM states, note-word
// field values and the 50 MHz half-period table.
package music_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    LOAD,
    PLAY
  } state_t;

  localparam int unsigned HALF_W     = 17;
  localparam logic [3:0]  DUR_END    = 4'd0;
  localparam logic [3:0]  PITCH_REST = 4'd0;
  localparam logic [3:0]  PITCH_HIGH_REST = 4'd15;

  // Half-period in 50 MHz cycles; the upper octave is the lower one halved.
  function automatic logic [HALF_W-1:0] half_period(input logic [3:0] pitch);
    case (pitch)
      4'd1:    half_period = 17'd95556;
      4'd2:    half_period = 17'd85131;
      4'd3:    half_period = 17'd75843;
      4'd4:    half_period = 17'd71586;
      4'd5:    half_period = 17'd63776;
      4'd6:    half_period = 17'd56818;
      4'd7:    half_period = 17'd50619;
      4'd8:    half_period = 17'd47778;
      4'd9:    half_period = 17'd42565;
      4'd10:   half_period = 17'd37921;
      4'd11:   half_period = 17'd35793;
      4'd12:   half_period = 17'd31888;
      4'd13:   half_period = 17'd28409;
      4'd14:   half_period = 17'd25309;
      default: half_period = '0;
    endcase
  endfunction

  function automatic logic is_rest(input logic [3:0] pitch);
    is_rest = (pitch == PITCH_REST) || (pitch == PITCH_HIGH_REST);
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: toggles the speaker every `half` cycles while running,
// restarts from a low level on load, and stays low for rest notes.
module tone_gen
  import music_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              run,
  input  logic [HALF_W-1:0] half,
  input  logic              mute,
  output logic              speaker
);

  logic [HALF_W-1:0] half_q;
  logic [HALF_W-1:0] count;
  logic              mute_q;
  logic              wrap;

  assign wrap = ({1'b0, count} + {{HALF_W{1'b0}}, 1'b1}) >= {1'b0, half_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      half_q  <= '0;
      count   <= '0;
      mute_q  <= 1'b0;
      speaker <= 1'b0;
    end else if (load) begin
      half_q  <= half;
      mute_q  <= mute;
      count   <= '0;
      speaker <= 1'b0;
    end else if (run) begin
      if (wrap) begin
        count   <= '0;
        speaker <= ~speaker & ~mute_q;
      end else begin
        count <= count + {{(HALF_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/note_player.sv
// Walks the song ROM one note word at a time, holding each pitch for its
// beat count and driving the speaker through tone_gen.
module note_player
  import music_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 12_500_000,
  parameter int unsigned TONE_SHIFT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       sel,
  input  logic [7:0] note_data,
  output logic [7:0] addr,
  output logic       speaker,
  output logic       busy,
  output logic       song_done
);

  localparam int unsigned TW = $clog2(TICK_DIV);

  state_t            state;
  state_t            next;
  logic              sel_q;
  logic [6:0]        idx;
  logic [TW-1:0]     tick;
  logic [3:0]        beats;
  logic              tick_wrap;
  logic              done_next;
  logic              load_tone;
  logic [3:0]        dur;
  logic [3:0]        pitch;
  logic [HALF_W-1:0] half;

  assign dur       = note_data[7:4];
  assign pitch     = note_data[3:0];
  assign half      = half_period(pitch) >> TONE_SHIFT;
  assign tick_wrap = (tick == TW'(TICK_DIV - 1));
  assign addr      = {sel_q, idx};
  assign busy      = (state != IDLE);

  always_comb begin
    next      = state;
    done_next = 1'b0;
    case (state)
      IDLE:  if (en) next = FETCH;
      FETCH: next = LOAD;
      LOAD: begin
        if (dur == DUR_END) begin
          next      = IDLE;
          done_next = en;
        end else begin
          next = PLAY;
        end
      end
      PLAY:  if (tick_wrap && beats == 4'd1) next = FETCH;
      default: next = IDLE;
    endcase
    // Dropping en is a stop, and it outranks the end-marker pulse.
    if (state != IDLE && !en) next = IDLE;
    load_tone = (state == LOAD) || (next == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sel_q     <= 1'b0;
      idx       <= '0;
      tick      <= '0;
      beats     <= '0;
      song_done <= 1'b0;
    end else begin
      state     <= next;
      song_done <= done_next;
      if (state == IDLE) sel_q <= sel;
      if (next == IDLE) idx <= '0;
      else if (state == PLAY && next == FETCH) idx <= idx + 7'd1;
      if (state == LOAD) begin
        beats <= dur;
        tick  <= '0;
      end else if (state == PLAY) begin
        if (tick_wrap) begin
          tick  <= '0;
          beats <= beats - 4'd1;
        end else begin
          tick <= tick + TW'(1);
        end
      end
    end
  end

  tone_gen u_tone (
    .clk     (clk),
    .reset   (reset),
    .load    (load_tone),
    .run     (state == PLAY),
    .half    (half),
    .mute    (is_rest(pitch)),
    .speaker (speaker)
  );

endmodule

// File: tb/tb_note_player.sv
// Scoreboard bench for note_player: a timeline model built from note words
// predicts every output change; a monitor pops and compares on each change.
module tb_note_player;

  localparam int TD   = 100;
  localparam int TS   = 8;
  localparam int MAXL = 14000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       sel = 1'b0;
  logic [7:0] note_data;
  logic [7:0] addr;
  logic       speaker;
  logic       busy;
  logic       song_done;

  logic [7:0] rom [256];

  note_player #(.TICK_DIV(TD), .TONE_SHIFT(TS)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .sel       (sel),
    .note_data (note_data),
    .addr      (addr),
    .speaker   (speaker),
    .busy      (busy),
    .song_done (song_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) note_data <= rom[addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [7:0] a;
    logic       s;
    logic       b;
    logic       d;
  } ev_t;

  ev_t q[$];
  int  vectors = 0;
  int  miscompares = 0;

  // scenario parameters: D = first edge sampling en=0, R = reset edge, Sc = sel change edge
  int L, D, R, Sc, base;
  bit s0, s1;
  bit mon_on = 1'b0;

  logic [7:0] ea [MAXL];
  bit         es [MAXL];
  bit         eb [MAXL];
  bit         ed [MAXL];

  int base_tab [7] = '{95556, 85131, 75843, 71586, 63776, 56818, 50619};

  function automatic bit sel_at(int e);
    return (e >= Sc) ? s1 : s0;
  endfunction

  function automatic int halfp(int p);
    if (p >= 1 && p <= 7) return base_tab[p-1] >> TS;
    if (p >= 8 && p <= 14) return (base_tab[p-8] / 2) >> TS;
    return 0;
  endfunction

  function automatic void put(int c, logic [7:0] a, bit s, bit b, bit d, int cut);
    if (c < cut && c < L) begin
      ea[c] = a; es[c] = s; eb[c] = b; ed[c] = d;
    end
  endfunction

  // Song playback starting with the start edge t0, truncated at edge `cut`.
  function automatic void fill_play(int t0, int cut);
    int t, idx, dur, p, h, plen;
    bit s, hold;
    logic [7:0] w;
    t = t0;
    while (t < cut && t < L) begin
      s = sel_at(t); idx = 0; hold = 1'b0;
      while (t < cut && t < L) begin
        put(t,   {s, 7'(idx)}, hold, 1'b1, 1'b0, cut);
        put(t+1, {s, 7'(idx)}, hold, 1'b1, 1'b0, cut);
        w = rom[{s, 7'(idx)}];
        dur = int'(w[7:4]);
        p = int'(w[3:0]);
        if (dur == 0) begin
          put(t+2, {s, 7'd0}, 1'b0, 1'b0, 1'b1, cut);
          t = t + 3;
          break;
        end
        h = halfp(p);
        plen = dur * TD;
        for (int k = 0; k < plen; k++)
          put(t+2+k, {s, 7'(idx)}, (h == 0) ? 1'b0 : 1'((k / h) % 2), 1'b1, 1'b0, cut);
        hold = (h == 0) ? 1'b0 : 1'((plen / h) % 2);
        idx = (idx + 1) % 128;
        t = t + 2 + plen;
      end
    end
  endfunction

  function automatic void build();
    logic [7:0] pa;
    bit ps, pb, pd;
    ev_t e;
    for (int c = 0; c < L; c++) begin
      ea[c] = {sel_at(c), 7'd0}; es[c] = 0; eb[c] = 0; ed[c] = 0;
    end
    if (R >= 0) begin
      fill_play(0, R);
      ea[R] = 8'h00; es[R] = 0; eb[R] = 0; ed[R] = 0;
      fill_play(R + 1, L);
    end else begin
      fill_play(0, D);
      if (D > 0 && D < L && eb[D-1]) ea[D] = {ea[D-1][7], 7'd0};
    end
    pa = {s0, 7'd0}; ps = 0; pb = 0; pd = 0;
    for (int c = 0; c < L; c++) begin
      if (ea[c] != pa || es[c] != ps || eb[c] != pb || ed[c] != pd) begin
        e.c = c; e.a = ea[c]; e.s = es[c]; e.b = eb[c]; e.d = ed[c];
        q.push_back(e);
      end
      pa = ea[c]; ps = es[c]; pb = eb[c]; pd = ed[c];
    end
  endfunction

  logic [7:0] m_a;
  logic       m_s, m_b, m_d;
  always @(negedge clk) begin
    ev_t e;
    if (mon_on && (addr !== m_a || speaker !== m_s || busy !== m_b || song_done !== m_d)) begin
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_change: cycle %0d addr=%h spk=%b busy=%b done=%b, required no change",
                 cyc - base, addr, speaker, busy, song_done);
      end else begin
        e = q.pop_front();
        if (e.c != cyc - base || e.a !== addr || e.s !== speaker || e.b !== busy || e.d !== song_done) begin
          miscompares++;
          $display("FAIL output_change: got cycle %0d addr=%h spk=%b busy=%b done=%b, required cycle %0d addr=%h spk=%b busy=%b done=%b",
                   cyc - base, addr, speaker, busy, song_done, e.c, e.a, e.s, e.b, e.d);
        end
      end
    end
    m_a = addr; m_s = speaker; m_b = busy; m_d = song_done;
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic run_scn();
    ev_t e;
    @(negedge clk);
    reset = 1'b1; en = 1'b0; sel = s0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_addr", addr, {s0, 7'd0});
    chk("idle_busy", {7'd0, busy}, 8'h00);
    chk("idle_speaker", {7'd0, speaker}, 8'h00);
    chk("idle_done", {7'd0, song_done}, 8'h00);
    build();
    base = cyc + 1;
    mon_on = 1'b1;
    en = 1'b1;
    for (int c = 0; c < L; c++) begin
      @(negedge clk);
      en    = (c + 1 < D);
      reset = (c + 1 == R);
      sel   = sel_at(c + 1);
    end
    @(posedge clk);
    mon_on = 1'b0;
    en = 1'b0;
    while (q.size() > 0) begin
      e = q.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL missing_change: required cycle %0d addr=%h spk=%b busy=%b done=%b, got none",
               e.c, e.a, e.s, e.b, e.d);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
  endtask

  task automatic rand_song(input bit s, input int n);
    for (int i = 0; i < n; i++)
      rom[{s, 7'(i)}] = {4'($urandom_range(1, 3)), 4'($urandom_range(0, 15))};
  endtask

  task automatic defaults(input bit s);
    s0 = s; s1 = s; Sc = MAXL; R = -1;
  endtask

  initial begin
    clear_rom();

    // A4 for two beats, then end marker
    defaults(1'b0); rom[0] = 8'h26; rom[1] = 8'h00; L = 220; D = 205;
    run_scn();

    // song 1, C4 for one beat
    clear_rom(); defaults(1'b1); rom[8'h80] = 8'h11; rom[8'h81] = 8'h00; L = 120; D = 105;
    run_scn();

    // rest for three beats
    clear_rom(); defaults(1'b0); rom[0] = 8'h30; rom[1] = 8'h00; L = 320; D = 305;
    run_scn();

    // end marker at index 0, en held: repeated empty songs
    clear_rom(); defaults(1'b0); L = 12; D = L + 10;
    run_scn();

    // 128 one-beat notes: index wraps without touching the song bit
    clear_rom(); defaults(1'b1);
    for (int i = 0; i < 128; i++) rom[128 + i] = {4'd1, 4'($urandom_range(0, 15))};
    L = 128 * (TD + 2) + 104; D = L + 10;
    run_scn();

    // en dropped mid-note
    clear_rom(); defaults(1'($urandom_range(0, 1))); rand_song(s0, 3);
    D = 2 + $urandom_range(1, 150); L = D + 20;
    run_scn();

    // reset pulsed during PLAY, en still high
    clear_rom(); defaults(1'b1); rand_song(1'b1, 3);
    R = $urandom_range(5, 90); L = R + 150; D = L + 10;
    run_scn();

    // random songs in both halves with a sel change while busy
    for (int n = 0; n < 6; n++) begin
      clear_rom();
      rand_song(1'b0, $urandom_range(0, 4));
      rand_song(1'b1, $urandom_range(0, 4));
      defaults(1'($urandom_range(0, 1)));
      L = 700;
      s1 = ~s0;
      Sc = $urandom_range(1, L - 1);
      D = ($urandom_range(0, 1) == 1) ? L + 10 : $urandom_range(3, L - 1);
      run_scn();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
